// File: rtl/mont_exp_ctrl_pkg.sv
// ============================================================================
// mont_pkg : shared widths and state encoding for the Montgomery exponent
//            sequencer.  Revision: 1.0
// ============================================================================
`default_nettype none

package mont_pkg;

    localparam int W_DEF      = 512;
    localparam int E_BITS_DEF = 512;
    localparam int IDX_W      = $clog2(E_BITS_DEF);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SCAN     = 3'd1,
        ST_SQ_GO    = 3'd2,
        ST_SQ_WAIT  = 3'd3,
        ST_MUL_GO   = 3'd4,
        ST_MUL_WAIT = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mont_exp_ctrl_if.sv
// ============================================================================
// mont_exp_ctrl_if : start/done handshake and operand bus to the Montgomery
//                    multiplier.  Revision: 1.0
// ============================================================================
`default_nettype none

interface mont_exp_ctrl_if #(
    parameter int W = 512
);
    logic         mul_start;
    logic [W-1:0] mul_a;
    logic [W-1:0] mul_b;
    logic [W-1:0] mul_m;
    logic [W-1:0] mul_result;
    logic         mul_done;

    modport master (
        output mul_start, mul_a, mul_b, mul_m,
        input  mul_result, mul_done
    );

    modport slave (
        input  mul_start, mul_a, mul_b, mul_m,
        output mul_result, mul_done
    );
endinterface

`default_nettype wire

// File: rtl/mont_exp_ctrl.sv
// ============================================================================
// mont_exp_ctrl : left-to-right square-and-multiply sequencer driving an
//                 external Montgomery multiplier.  Optional leading-zero skip
//                 enabled by MONTEXP_SKIP_LZ_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module mont_exp_ctrl
    import mont_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int E_BITS = E_BITS_DEF
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              start,
    input  wire logic [W-1:0]      in_x,
    input  wire logic [W-1:0]      in_rmodm,
    input  wire logic [W-1:0]      in_m,
    input  wire logic [E_BITS-1:0] in_e,
    output logic      [W-1:0]      result,
    output logic                   done,
    output logic                   busy,
    mont_exp_ctrl_if.master        mul
);

    localparam int             IW      = (E_BITS > 1) ? $clog2(E_BITS) : 1;
    localparam logic [IW-1:0]  IDX_TOP = IW'(E_BITS - 1);

    state_t              state_q, state_d;
    logic [W-1:0]        a_q, a_d;
    logic [W-1:0]        x_q, x_d;
    logic [W-1:0]        m_q, m_d;
    logic [E_BITS-1:0]   e_q, e_d;
    logic [IW-1:0]       idx_q, idx_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            x_q     <= '0;
            m_q     <= '0;
            e_q     <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            x_q     <= x_d;
            m_q     <= m_d;
            e_q     <= e_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        x_d     = x_q;
        m_d     = m_q;
        e_d     = e_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d   = in_x;
                    m_d   = in_m;
                    e_d   = in_e;
                    a_d   = in_rmodm;
                    idx_d = IDX_TOP;
`ifdef MONTEXP_SKIP_LZ_EN
                    state_d = ST_SCAN;
`else
                    state_d = ST_SQ_GO;
`endif
                end
            end
`ifdef MONTEXP_SKIP_LZ_EN
            ST_SCAN: begin
                // The leading one replaces square(1)*X with a plain copy of X.
                if (e_q[idx_q]) begin
                    a_d = x_q;
                    if (idx_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q - IW'(1);
                        state_d = ST_SQ_GO;
                    end
                end else if (idx_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
`endif
            ST_SQ_GO:  state_d = ST_SQ_WAIT;
            ST_SQ_WAIT: begin
                if (mul.mul_done) begin
                    a_d = mul.mul_result;
                    if (e_q[idx_q]) begin
                        state_d = ST_MUL_GO;
                    end else if (idx_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q - IW'(1);
                        state_d = ST_SQ_GO;
                    end
                end
            end
            ST_MUL_GO: state_d = ST_MUL_WAIT;
            ST_MUL_WAIT: begin
                if (mul.mul_done) begin
                    a_d = mul.mul_result;
                    if (idx_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q - IW'(1);
                        state_d = ST_SQ_GO;
                    end
                end
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Operands come straight from registers so they hold from GO through done.
    always_comb begin
        mul.mul_start = (state_q == ST_SQ_GO) || (state_q == ST_MUL_GO);
        mul.mul_a     = a_q;
        mul.mul_b     = ((state_q == ST_MUL_GO) || (state_q == ST_MUL_WAIT)) ? x_q : a_q;
        mul.mul_m     = m_q;
        result        = a_q;
        done          = (state_q == ST_DONE);
        busy          = (state_q != ST_IDLE);
    end

endmodule

`default_nettype wire

// File: tb/tb_mont_exp_ctrl.sv
// ============================================================================
// tb_mont_exp_ctrl : directed bench with a behavioural Montgomery multiplier
//                    and a result scoreboard.  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mont_exp_ctrl;
    import mont_pkg::*;

    localparam int              W   = 512;
    localparam int              EB  = 512;
    localparam longint unsigned MOD = 23;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  in_x = '0, in_rmodm = '0, in_m = '0;
    logic [EB-1:0] in_e = '0;
    logic [W-1:0]  result;
    logic          done, busy;

    mont_exp_ctrl_if #(.W(W)) mif ();

    logic [W-1:0]  m_res = '0;
    logic          m_done = 1'b0;
    logic          spur = 1'b0;
    assign mif.mul_result = m_res;
    assign mif.mul_done   = m_done | spur;

    mont_exp_ctrl #(.W(W), .E_BITS(EB)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_x     (in_x),
        .in_rmodm (in_rmodm),
        .in_m     (in_m),
        .in_e     (in_e),
        .result   (result),
        .done     (done),
        .busy     (busy),
        .mul      (mif)
    );

    always #5 clk = ~clk;

    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;
    int              pulses = 0;
    logic            prev_start = 1'b0;
    int              lm = 2;
    longint unsigned r_m = 1;
    longint unsigned rinv = 0;
    logic [W-1:0]    exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] to_mont(input longint unsigned v);
        return W'(((v % MOD) * r_m) % MOD);
    endfunction

    function automatic longint unsigned powm(input longint unsigned x, input int e);
        longint unsigned r = 1;
        for (int i = 0; i < e; i++) r = (r * x) % MOD;
        return r;
    endfunction

    function automatic int exp_pulses(input int e);
        int pop = 0;
        int msb = -1;
        for (int i = 0; i < 31; i++) if (e[i]) begin pop++; msb = i; end
`ifdef MONTEXP_SKIP_LZ_EN
        return (e == 0) ? 0 : msb + pop - 1;
`else
        return EB + pop;
`endif
    endfunction

    // Inclusive cycles from the start cycle to the done cycle; 0 = not checked.
    function automatic int exp_latency(input int e, input int lmv);
        int pop = 0;
        for (int i = 0; i < 31; i++) if (e[i]) pop++;
`ifdef MONTEXP_SKIP_LZ_EN
        return (e == 0) ? EB + 2 : 0;
`else
        return 2 + (EB + pop) * lmv;
`endif
    endfunction

    always @(negedge clk) begin
        if (mif.mul_start) begin
            pulses++;
            chk("no_back_to_back_start", W'(prev_start), W'(0));
        end
        prev_start = mif.mul_start;
    end

    // Behavioural multiplier: a*b*2^-W mod m, done Lm cycles after start, inclusive.
    initial begin
        logic [W-1:0]    a, b, mm;
        longint unsigned av, bv, mv;
        forever begin
            @(negedge clk);
            if (mif.mul_start && !reset) begin
                a  = mif.mul_a;
                b  = mif.mul_b;
                mm = mif.mul_m;
                repeat (lm - 1) @(posedge clk);
                #1;
                if (mm != '0) begin
                    mv    = 64'(mm);
                    av    = 64'(a % mm);
                    bv    = 64'(b % mm);
                    m_res = W'((((av * bv) % mv) * rinv) % mv);
                end else begin
                    m_res = '0;
                end
                m_done = 1'b1;
                @(posedge clk);
                #1 m_done = 1'b0;
            end
        end
    end

    task automatic do_run(input longint unsigned x, input int e, input int lmv,
                          input bit disturb, input int exp_lat);
        int s, p0, k;
        bit got;
        lm       = lmv;
        in_x     = to_mont(x);
        in_rmodm = to_mont(1);
        in_m     = W'(MOD);
        in_e     = EB'(e);
        @(negedge clk);
        start = 1'b1;
        s     = cyc;
        p0    = pulses;
        exp_q.push_back(to_mont(powm(x, e)));
        @(negedge clk);
        start = 1'b0;
        chk("busy_rise", W'(busy), W'(1));
        if (disturb) begin
            for (k = 0; k < 2000 && !(mif.mul_start && mif.mul_a == mif.mul_b); k++)
                @(negedge clk);
            chk("square_go_reached", W'(k < 2000), W'(1));
            start = 1'b1;
            spur  = 1'b1;
            @(negedge clk);
            start = 1'b0;
            spur  = 1'b0;
        end
        got = 1'b0;
        for (k = 0; k < 20000; k++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("done_seen", W'(got), W'(1));
        if (got) begin
            chk("result", result, exp_q.pop_front());
            chk("mul_pulses", W'(pulses - p0), W'(exp_pulses(e)));
            if (exp_lat > 0) chk("latency", W'(cyc - s + 1), W'(exp_lat));
            @(negedge clk);
            chk("done_one_cycle", W'(done), W'(0));
            chk("busy_low_after", W'(busy), W'(0));
            repeat (3) @(negedge clk);
            chk("result_hold", result, to_mont(powm(x, e)));
        end else begin
            exp_q.delete();
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_result"}, result, '0);
        chk({tag, "_done"}, W'(done), W'(0));
        chk({tag, "_busy"}, W'(busy), W'(0));
        chk({tag, "_mul_start"}, W'(mif.mul_start), W'(0));
        chk({tag, "_mul_a"}, mif.mul_a, '0);
        chk({tag, "_mul_b"}, mif.mul_b, '0);
        chk({tag, "_mul_m"}, mif.mul_m, '0);
    endtask

    initial begin
        int p0, k, target;
        for (int i = 0; i < EB; i++) r_m = (r_m * 2) % MOD;
        for (longint unsigned i = 1; i < MOD; i++) if (((r_m * i) % MOD) == 1) rinv = i;

        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        do_run(5, 3, 2, 1'b0, exp_latency(3, 2));
        do_run(5, 0, 2, 1'b0, exp_latency(0, 2));
        do_run(7, 1, 4, 1'b0, exp_latency(1, 4));
        do_run(5, 3, 2, 1'b1, exp_latency(3, 2));

        // Abort a run with reset while the multiply step is outstanding.
`ifdef MONTEXP_SKIP_LZ_EN
        target = 2;
`else
        target = EB;
`endif
        lm       = 3;
        in_x     = to_mont(5);
        in_rmodm = to_mont(1);
        in_m     = W'(MOD);
        in_e     = EB'(3);
        @(negedge clk);
        start = 1'b1;
        p0    = pulses;
        @(negedge clk);
        start = 1'b0;
        for (k = 0; k < 5000; k++) begin
            #1;
            if (pulses - p0 == target) break;
            @(negedge clk);
        end
        chk("mul_go_reached", W'(k < 5000 && mif.mul_b == in_x), W'(1));
        @(posedge clk);
        #1 reset = 1'b1;
        #1 chk_zero_outputs("async_reset");
        repeat (6) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_run(5, 3, 2, 1'b0, exp_latency(3, 2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
